// File: rtl/lsm_pkg.sv
// ============================================================================
//  Module      : lsm_pkg
//  Description : Shared types and constants for the load-store stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } lsm_state_t;

    localparam logic [3:0] LS_SEL_BYTE = 4'b0001;
    localparam logic [3:0] LS_SEL_HALF = 4'b0011;
    localparam logic [3:0] LS_SEL_WORD = 4'b1111;

    // Halves must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [3:0] sel, input logic [1:0] offset);
        logic res;
        res = 1'b0;
        if (sel == LS_SEL_HALF) begin
            res = offset[0];
        end else if (sel == LS_SEL_WORD) begin
            res = (offset != 2'b00);
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsm_if.sv
// ============================================================================
//  Module      : lsm_if
//  Description : Pipelined Wishbone B4 bus between the load-store stage and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsm_if;

    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        stall;

    modport master (
        output adr, dat_w, sel, we, stb, cyc,
        input  dat_r, ack, stall
    );

    modport slave (
        input  adr, dat_w, sel, we, stb, cyc,
        output dat_r, ack, stall
    );

endinterface

`default_nettype wire

// File: rtl/lsm_load_align.sv
// ============================================================================
//  Module      : lsm_load_align
//  Description : Shifts the addressed lanes of a load word down and extends them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsm_load_align
    import lsm_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_offset,
    input  logic [3:0]  i_sel,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_data >> {i_offset, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_sel)
            LS_SEL_BYTE: o_data = {{24{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            LS_SEL_HALF: o_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default:     o_data = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsm.sv
// ============================================================================
//  Module      : lsm
//  Description : Load-store stage between execute and write-back, one Wishbone
//                access per load/store. Optional macro LSM_MISALIGN_TRAP_EN
//                suppresses misaligned accesses and adds misaligned_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsm
    import lsm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,

    output logic        input_ready_o,
    input  logic        input_valid_i,
    input  logic [31:0] result_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        ls_unsigned_load_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,

    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o,

    lsm_if.master       wb
`ifdef LSM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned_o
`endif
);

    lsm_state_t  r_state, w_state_d;

    logic        r_valid,     w_valid_d;
    logic        r_reg_write, w_reg_write_d;
    logic [4:0]  r_reg_addr,  w_reg_addr_d;
    logic [31:0] r_reg_data,  w_reg_data_d;

    logic        r_cyc, w_cyc_d;
    logic        r_stb, w_stb_d;
    logic        r_we,  w_we_d;
    logic [3:0]  r_sel, w_sel_d;
    logic [31:0] r_adr, w_adr_d;
    logic [31:0] r_dat, w_dat_d;

    // Context of the in-flight access, needed when the ack returns.
    logic [1:0]  r_off,        w_off_d;
    logic [3:0]  r_ld_sel,     w_ld_sel_d;
    logic        r_uns,        w_uns_d;
    logic        r_pend_write, w_pend_write_d;
    logic [4:0]  r_pend_addr,  w_pend_addr_d;

    logic        w_accept;
    logic [3:0]  w_lane_sel;
    logic [31:0] w_load_data;

`ifdef LSM_MISALIGN_TRAP_EN
    logic        r_mis, w_mis_d;
    logic        w_misaligned;

    assign w_misaligned = is_misaligned(ls_sel_i, result_i[1:0]);
    assign misaligned_o = r_mis;
`endif

    assign input_ready_o = ~rst_i & (r_state == IDLE) & ~(r_valid & ~output_ready_i);
    assign w_accept      = input_valid_i & input_ready_o;
    // Lanes pushed past bit 3 are simply dropped.
    assign w_lane_sel    = ls_sel_i << result_i[1:0];

    lsm_load_align u_load_align (
        .i_data     (wb.dat_r),
        .i_offset   (r_off),
        .i_sel      (r_ld_sel),
        .i_unsigned (r_uns),
        .o_data     (w_load_data)
    );

    always_comb begin
        w_state_d      = r_state;
        w_valid_d      = r_valid & ~output_ready_i;
        w_reg_write_d  = r_reg_write;
        w_reg_addr_d   = r_reg_addr;
        w_reg_data_d   = r_reg_data;
        w_cyc_d        = r_cyc;
        w_stb_d        = r_stb;
        w_we_d         = r_we;
        w_sel_d        = r_sel;
        w_adr_d        = r_adr;
        w_dat_d        = r_dat;
        w_off_d        = r_off;
        w_ld_sel_d     = r_ld_sel;
        w_uns_d        = r_uns;
        w_pend_write_d = r_pend_write;
        w_pend_addr_d  = r_pend_addr;
`ifdef LSM_MISALIGN_TRAP_EN
        w_mis_d        = r_mis & ~output_ready_i;
`endif

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!ls_enable_i) begin
                        w_valid_d     = 1'b1;
                        w_reg_write_d = reg_write_i & input_valid_i;
                        w_reg_addr_d  = reg_addr_i;
                        w_reg_data_d  = result_i;
`ifdef LSM_MISALIGN_TRAP_EN
                    end else if (w_misaligned) begin
                        w_valid_d     = 1'b1;
                        w_reg_write_d = 1'b0;
                        w_reg_addr_d  = reg_addr_i;
                        w_reg_data_d  = 32'd0;
                        w_mis_d       = 1'b1;
`endif
                    end else begin
                        w_state_d      = REQUEST;
                        w_cyc_d        = 1'b1;
                        w_stb_d        = 1'b1;
                        w_we_d         = ls_write_i;
                        w_adr_d        = {result_i[31:2], 2'b00};
                        w_sel_d        = w_lane_sel;
                        w_dat_d        = ls_write_data_i << {result_i[1:0], 3'b000};
                        w_off_d        = result_i[1:0];
                        w_ld_sel_d     = ls_sel_i;
                        w_uns_d        = ls_unsigned_load_i;
                        w_pend_write_d = reg_write_i & ~ls_write_i;
                        w_pend_addr_d  = reg_addr_i;
                    end
                end
            end

            REQUEST: begin
                if (!wb.stall) begin
                    w_stb_d   = 1'b0;
                    w_state_d = WAIT_ACK;
                    if (wb.ack) begin
                        w_cyc_d       = 1'b0;
                        w_state_d     = DONE;
                        w_valid_d     = 1'b1;
                        w_reg_write_d = r_pend_write;
                        w_reg_addr_d  = r_pend_addr;
                        w_reg_data_d  = r_we ? 32'd0 : w_load_data;
                    end
                end
            end

            WAIT_ACK: begin
                if (wb.ack) begin
                    w_cyc_d       = 1'b0;
                    w_state_d     = DONE;
                    w_valid_d     = 1'b1;
                    w_reg_write_d = r_pend_write;
                    w_reg_addr_d  = r_pend_addr;
                    w_reg_data_d  = r_we ? 32'd0 : w_load_data;
                end
            end

            DONE: begin
                if (output_ready_i) begin
                    w_state_d = IDLE;
                end
            end

            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_reg_addr   <= 5'd0;
            r_reg_data   <= 32'd0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= 4'd0;
            r_adr        <= 32'd0;
            r_dat        <= 32'd0;
            r_off        <= 2'd0;
            r_ld_sel     <= 4'd0;
            r_uns        <= 1'b0;
            r_pend_write <= 1'b0;
            r_pend_addr  <= 5'd0;
        end else begin
            r_state      <= w_state_d;
            r_valid      <= w_valid_d;
            r_reg_write  <= w_reg_write_d;
            r_reg_addr   <= w_reg_addr_d;
            r_reg_data   <= w_reg_data_d;
            r_cyc        <= w_cyc_d;
            r_stb        <= w_stb_d;
            r_we         <= w_we_d;
            r_sel        <= w_sel_d;
            r_adr        <= w_adr_d;
            r_dat        <= w_dat_d;
            r_off        <= w_off_d;
            r_ld_sel     <= w_ld_sel_d;
            r_uns        <= w_uns_d;
            r_pend_write <= w_pend_write_d;
            r_pend_addr  <= w_pend_addr_d;
        end
    end

`ifdef LSM_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mis <= 1'b0;
        end else begin
            r_mis <= w_mis_d;
        end
    end
`endif

    assign output_valid_o = r_valid;
    assign reg_write_o    = r_reg_write;
    assign reg_addr_o     = r_reg_addr;
    assign reg_data_o     = r_reg_data;

    assign wb.cyc   = r_cyc;
    assign wb.stb   = r_stb;
    assign wb.we    = r_we;
    assign wb.sel   = r_sel;
    assign wb.adr   = r_adr;
    assign wb.dat_w = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_lsm.sv
// ============================================================================
//  Module      : tb_lsm
//  Description : Randomized self-checking bench for the load-store stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsm;

    logic        clk;
    logic        rst;
    logic        input_ready;
    logic        input_valid;
    logic [31:0] result;
    logic        ls_enable;
    logic        ls_write;
    logic [31:0] ls_write_data;
    logic [3:0]  ls_sel;
    logic        ls_unsigned;
    logic        reg_write_in;
    logic [4:0]  reg_addr_in;
    logic        output_ready;
    logic        output_valid;
    logic        reg_write_out;
    logic [4:0]  reg_addr_out;
    logic [31:0] reg_data_out;

    int n_checks = 0;
    int n_errors = 0;

    lsm_if wb ();

`ifdef LSM_MISALIGN_TRAP_EN
    logic misaligned;
`endif

    lsm dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .input_ready_o      (input_ready),
        .input_valid_i      (input_valid),
        .result_i           (result),
        .ls_enable_i        (ls_enable),
        .ls_write_i         (ls_write),
        .ls_write_data_i    (ls_write_data),
        .ls_sel_i           (ls_sel),
        .ls_unsigned_load_i (ls_unsigned),
        .reg_write_i        (reg_write_in),
        .reg_addr_i         (reg_addr_in),
        .output_ready_i     (output_ready),
        .output_valid_o     (output_valid),
        .reg_write_o        (reg_write_out),
        .reg_addr_o         (reg_addr_out),
        .reg_data_o         (reg_data_out),
        .wb                 (wb)
`ifdef LSM_MISALIGN_TRAP_EN
        ,
        .misaligned_o       (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference load result: pick the addressed bytes one by one, zero past the word end.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [3:0] sel, input logic uns);
        int n;
        logic [31:0] v;
        n = (sel == 4'b0001) ? 1 : (sel == 4'b0011) ? 2 : 4;
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (int'(off) + i < 4) v[8*i +: 8] = word[8*(int'(off) + i) +: 8];
        end
        if (!uns && n < 4 && v[8*n - 1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // kind: 0 = ALU pass-through, 1 = load, 2 = store
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [3:0] sel, input logic uns,
                         input logic regw, input logic [4:0] ra,
                         input int stall_n, input int ack_n, input int ready_n);
        logic [31:0] exp_data;
        logic        exp_w;
        logic [31:0] exp_adr;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;
        int          off;
        off     = int'(addr[1:0]);
        exp_adr = {addr[31:2], 2'b00};
        exp_sel = 4'((8'(sel) << off) & 8'h0F);
        exp_dat = 32'(64'(wdata) << (8 * off));

        @(negedge clk);
        check("idle_ready", 32'(input_ready), 32'd1);
        check("idle_valid", 32'(output_valid), 32'd0);
        input_valid   = 1'b1;
        result        = addr;
        ls_enable     = (kind != 0);
        ls_write      = (kind == 2);
        ls_write_data = wdata;
        ls_sel        = sel;
        ls_unsigned   = uns;
        reg_write_in  = regw;
        reg_addr_in   = ra;
        output_ready  = 1'b0;

        @(negedge clk);
        // Keep a junk instruction offered; it must not be taken while busy.
        ls_enable = 1'b0;
        result    = $urandom;
        reg_addr_in = 5'($urandom);

        if (kind == 0) begin
            exp_data = addr;
            exp_w    = regw;
        end else begin
            check("bus_cyc", 32'(wb.cyc), 32'd1);
            check("bus_stb", 32'(wb.stb), 32'd1);
            check("bus_adr", wb.adr, exp_adr);
            check("bus_sel", 32'(wb.sel), 32'(exp_sel));
            check("bus_we",  32'(wb.we), 32'(kind == 2));
            if (kind == 2) check("bus_dat", wb.dat_w, exp_dat);
            check("busy_ready", 32'(input_ready), 32'd0);
            for (int i = 0; i < stall_n; i++) begin
                wb.stall = 1'b1;
                @(negedge clk);
                check("stall_stb", 32'(wb.stb), 32'd1);
                check("stall_adr", wb.adr, exp_adr);
                check("stall_sel", 32'(wb.sel), 32'(exp_sel));
                if (kind == 2) check("stall_dat", wb.dat_w, exp_dat);
            end
            wb.stall = 1'b0;
            wb.ack   = (ack_n == 0);
            wb.dat_r = (ack_n == 0) ? rdata : $urandom;
            @(negedge clk);
            wb.ack = 1'b0;
            if (ack_n > 0) begin
                check("wait_stb", 32'(wb.stb), 32'd0);
                check("wait_cyc", 32'(wb.cyc), 32'd1);
                for (int i = 0; i < ack_n - 1; i++) begin
                    @(negedge clk);
                    check("wait_cyc", 32'(wb.cyc), 32'd1);
                    check("wait_valid", 32'(output_valid), 32'd0);
                end
                wb.ack   = 1'b1;
                wb.dat_r = rdata;
                @(negedge clk);
                wb.ack = 1'b0;
            end
            wb.dat_r = $urandom;
            check("done_cyc", 32'(wb.cyc), 32'd0);
            exp_data = ref_load(rdata, addr[1:0], sel, uns);
            exp_w    = (kind == 1) ? regw : 1'b0;
        end

        check("out_valid", 32'(output_valid), 32'd1);
        check("out_write", 32'(reg_write_out), 32'(exp_w));
        check("out_addr",  32'(reg_addr_out), 32'(ra));
        if (kind != 2) check("out_data", reg_data_out, exp_data);
        for (int i = 0; i < ready_n; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(output_valid), 32'd1);
            check("hold_addr", 32'(reg_addr_out), 32'(ra));
            if (kind != 2) check("hold_data", reg_data_out, exp_data);
            check("hold_ready", 32'(input_ready), 32'd0);
        end
        output_ready = 1'b1;
        input_valid  = 1'b0;
        @(negedge clk);
        check("drop_valid", 32'(output_valid), 32'd0);
    endtask

    task automatic reset_mid_access();
        @(negedge clk);
        input_valid  = 1'b1;
        result       = 32'h0000_0400;
        ls_enable    = 1'b1;
        ls_write     = 1'b0;
        ls_sel       = 4'b1111;
        reg_write_in = 1'b1;
        reg_addr_in  = 5'd9;
        output_ready = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        wb.stall    = 1'b0;
        wb.ack      = 1'b0;
        @(negedge clk);
        check("rst_pre_cyc", 32'(wb.cyc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cyc", 32'(wb.cyc), 32'd0);
        check("rst_stb", 32'(wb.stb), 32'd0);
        check("rst_ready", 32'(input_ready), 32'd0);
        rst      = 1'b0;
        wb.ack   = 1'b1;
        wb.dat_r = 32'h1234_5678;
        @(negedge clk);
        wb.ack = 1'b0;
        check("late_ack_valid", 32'(output_valid), 32'd0);
        @(negedge clk);
        check("late_ack_valid2", 32'(output_valid), 32'd0);
        check("late_ack_ready", 32'(input_ready), 32'd1);
    endtask

    initial begin
        int          kind;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [3:0]  sel_tab [3];
        sel_tab[0] = 4'b0001;
        sel_tab[1] = 4'b0011;
        sel_tab[2] = 4'b1111;

        rst = 1'b1;
        input_valid = 1'b0; result = '0; ls_enable = 1'b0; ls_write = 1'b0;
        ls_write_data = '0; ls_sel = '0; ls_unsigned = 1'b0; reg_write_in = 1'b0;
        reg_addr_in = '0; output_ready = 1'b1;
        wb.dat_r = '0; wb.ack = 1'b0; wb.stall = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(output_valid), 32'd0);
        check("rst_in_ready", 32'(input_ready), 32'd0);
        check("rst_reg_write", 32'(reg_write_out), 32'd0);
        check("rst_reg_addr", 32'(reg_addr_out), 32'd0);
        check("rst_reg_data", reg_data_out, 32'd0);
        check("rst_wb_cyc", 32'(wb.cyc), 32'd0);
        check("rst_wb_stb", 32'(wb.stb), 32'd0);
        check("rst_wb_we", 32'(wb.we), 32'd0);
        check("rst_wb_sel", 32'(wb.sel), 32'd0);
        check("rst_wb_adr", wb.adr, 32'd0);
        check("rst_wb_dat", wb.dat_w, 32'd0);
        rst = 1'b0;

        // Directed cases
        do_op(0, 32'h0000_1234, 32'd0, 32'd0, 4'b1111, 1'b0, 1'b1, 5'd5, 0, 0, 0);
        do_op(1, 32'h0000_0103, 32'd0, 32'h8000_0000, 4'b0001, 1'b0, 1'b1, 5'd6, 0, 0, 0);
        do_op(1, 32'h0000_0202, 32'd0, 32'hBEEF_0000, 4'b0011, 1'b1, 1'b1, 5'd7, 0, 1, 0);
        do_op(2, 32'h0000_0301, 32'h0000_00AB, 32'd0, 4'b0001, 1'b0, 1'b1, 5'd8, 3, 0, 0);
        do_op(1, 32'h0000_0400, 32'd0, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1, 5'd10, 0, 4, 2);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 2));
            sel  = sel_tab[$urandom_range(0, 2)];
            addr = $urandom;
`ifdef LSM_MISALIGN_TRAP_EN
            if (kind != 0) addr[1:0] = 2'b00;
`endif
            do_op(kind, addr, $urandom, $urandom, sel, 1'($urandom), 1'($urandom),
                  5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
        end

        reset_mid_access();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
